// File: rtl/cluster_vector_loader_pkg.sv
// Shared constants and state encoding for the cluster vector loader.
package cluster_vec_pkg;

  // Default geometry of the evaluator interface.
  localparam int DEF_VEC_W     = 1894;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_CNT_W     = 32;
  localparam int DEF_NUM_WORDS = (DEF_VEC_W + DEF_WORD_W - 1) / DEF_WORD_W;
  localparam int DEF_LAST_BITS = DEF_VEC_W - (DEF_NUM_WORDS - 1) * DEF_WORD_W;

  // Loader FSM state encoding.
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Number of WORD_W-bit words needed to cover a vector of the given width.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/cluster_vector_loader_sat_counter.sv
// Enable-increment counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: step by one while enabled and not yet saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cluster_vector_loader.sv
// Assembles the evaluator state vector from a word stream, samples the
// evaluator result bit, checks it against the frame's expected bit and keeps
// running test/error counts.
module cluster_vector_loader
  import cluster_vec_pkg::*;
#(
  parameter int VEC_W    = DEF_VEC_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int EVAL_LAT = 1,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_exp,
  output logic [VEC_W-1:0]  vec,
  input  logic              eval_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_bit,
  output logic              res_match,
  output logic [CNT_W-1:0]  test_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              frame_err
);

  localparam int NUM_WORDS = ceil_div(VEC_W, WORD_W);
  localparam int LAST_BITS = VEC_W - (NUM_WORDS - 1) * WORD_W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WAIT_W    = (EVAL_LAT > 1) ? $clog2(EVAL_LAT + 1) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EVAL_LAT);

  logic [1:0]        state_d, state_q;
  logic [IDX_W-1:0]  word_idx_d, word_idx_q;
  logic [WAIT_W-1:0] wait_d, wait_q;
  logic [VEC_W-1:0]  vec_d, vec_q;
  logic              exp_d, exp_q;
  logic              res_valid_d, res_valid_q;
  logic              res_bit_d, res_bit_q;
  logic              res_match_d, res_match_q;
  logic              frame_err_d, frame_err_q;

  logic              xfer_s;
  logic              sample_s;
  logic              mismatch_s;

  // Next-state logic for the FSM, word index, wait counter, vector and result.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    wait_d      = wait_q;
    vec_d       = vec_q;
    exp_d       = exp_q;
    res_valid_d = res_valid_q;
    res_bit_d   = res_bit_q;
    res_match_d = res_match_q;
    frame_err_d = frame_err_q;
    sample_s    = 1'b0;
    mismatch_s  = 1'b0;
    xfer_s      = in_valid && (state_q == ST_LOAD);

    case (state_q)
      ST_LOAD: begin
        if (xfer_s) begin
          // Full words land in place; the final word only fills the top bits.
          for (int k = 0; k < NUM_WORDS - 1; k++) begin
            if (word_idx_q == IDX_W'(k)) begin
              vec_d[k*WORD_W +: WORD_W] = in_data;
            end else begin
              vec_d[k*WORD_W +: WORD_W] = vec_q[k*WORD_W +: WORD_W];
            end
          end
          if (word_idx_q == LAST_IDX) begin
            vec_d[VEC_W-1 -: LAST_BITS] = in_data[LAST_BITS-1:0];
          end else begin
            vec_d[VEC_W-1 -: LAST_BITS] = vec_q[VEC_W-1 -: LAST_BITS];
          end

          if (word_idx_q == LAST_IDX) begin
            word_idx_d = IDX_ZERO;
            if (in_last) begin
              exp_d   = in_exp;
              wait_d  = WAIT_LOAD;
              state_d = ST_EVAL;
            end else begin
              // Frame ran past its last word without a terminator.
              frame_err_d = 1'b1;
            end
          end else if (in_last) begin
            // Terminator arrived early: drop the frame, restart at word 0.
            frame_err_d = 1'b1;
            word_idx_d  = IDX_ZERO;
          end else begin
            word_idx_d = word_idx_q + IDX_ONE;
          end
        end else begin
          word_idx_d = word_idx_q;
        end
      end

      ST_EVAL: begin
        if (wait_q == WAIT_ONE) begin
          sample_s    = 1'b1;
          mismatch_s  = (eval_o != exp_q);
          res_bit_d   = eval_o;
          res_match_d = (eval_o == exp_q);
          res_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wait_d = wait_q - WAIT_ONE;
        end
      end

      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end else begin
          res_valid_d = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover into LOAD with no result pending.
        state_d     = ST_LOAD;
        word_idx_d  = IDX_ZERO;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      word_idx_q  <= IDX_ZERO;
      wait_q      <= {WAIT_W{1'b0}};
      vec_q       <= {VEC_W{1'b0}};
      exp_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_match_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      wait_q      <= wait_d;
      vec_q       <= vec_d;
      exp_q       <= exp_d;
      res_valid_q <= res_valid_d;
      res_bit_q   <= res_bit_d;
      res_match_q <= res_match_d;
      frame_err_q <= frame_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_test_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sample_s),
    .cnt   (test_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mismatch_s),
    .cnt   (err_cnt)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign vec       = vec_q;
  assign res_valid = res_valid_q;
  assign res_bit   = res_bit_q;
  assign res_match = res_match_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cluster_vector_loader.sv
// Directed bench: two loaders (EVAL_LAT 1 and 3) fed the same stream in lockstep,
// each with its evaluator modelled as vec[78].
module tb_cluster_vector_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_last;
  logic        in_exp;
  logic        res_ready;
  logic [31:0] in_data;

  logic          in_ready_a, res_valid_a, res_bit_a, res_match_a, frame_err_a, eval_o_a;
  logic [1893:0] vec_a;
  logic [31:0]   test_cnt_a, err_cnt_a;
  logic          in_ready_b, res_valid_b, res_bit_b, res_match_b, frame_err_b, eval_o_b;
  logic [1893:0] vec_b;
  logic [31:0]   test_cnt_b, err_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] words [60];
  int lat_a, lat_b;

  always #5 clk = ~clk;

  assign eval_o_a = vec_a[78];
  assign eval_o_b = vec_b[78];

  cluster_vector_loader #(.VEC_W(1894), .WORD_W(32), .EVAL_LAT(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .in_exp(in_exp), .vec(vec_a),
    .eval_o(eval_o_a), .res_valid(res_valid_a), .res_ready(res_ready),
    .res_bit(res_bit_a), .res_match(res_match_a), .test_cnt(test_cnt_a),
    .err_cnt(err_cnt_a), .frame_err(frame_err_a)
  );

  cluster_vector_loader #(.VEC_W(1894), .WORD_W(32), .EVAL_LAT(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .in_exp(in_exp), .vec(vec_b),
    .eval_o(eval_o_b), .res_valid(res_valid_b), .res_ready(res_ready),
    .res_bit(res_bit_b), .res_match(res_match_b), .test_cnt(test_cnt_b),
    .err_cnt(err_cnt_b), .frame_err(frame_err_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_words();
    for (int i = 0; i < 60; i++) words[i] = 32'h0;
  endtask

  // Stream words[0..n-1]; in_last is raised on word last_at.
  task automatic send_words(input int n, input int last_at, input logic exp_bit);
    check_eq("ready_before_frame", {62'h0, in_ready_a, in_ready_b}, 64'h3);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = words[k];
      in_last  = (k == last_at);
      in_exp   = exp_bit;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'h0;
  endtask

  // Cycle index (relative to the last-word edge) at which each res_valid rises.
  task automatic wait_result(output int la, output int lb);
    la = 0;
    lb = 0;
    for (int c = 1; c <= 12; c++) begin
      if (res_valid_a && la == 0) la = c;
      if (res_valid_b && lb == 0) lb = c;
      if (la != 0 && lb != 0) break;
      step();
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic exp_bit, input logic rb,
                           input logic rm, input int tc, input int ec);
    send_words(60, 59, exp_bit);
    wait_result(lat_a, lat_b);
    check_eq({tag, "_lat1"}, lat_a, 2);
    check_eq({tag, "_lat3"}, lat_b, 4);
    check_eq({tag, "_res_bit"}, res_bit_a, rb);
    check_eq({tag, "_res_match"}, res_match_a, rm);
    check_eq({tag, "_test_cnt"}, test_cnt_a, tc);
    check_eq({tag, "_err_cnt"}, err_cnt_a, ec);
    check_eq({tag, "_res_bit_b"}, res_bit_b, rb);
    check_eq({tag, "_test_cnt_b"}, test_cnt_b, tc);
    check_eq({tag, "_in_ready_resp"}, in_ready_a, 1'b0);
    ack();
    check_eq({tag, "_in_ready_after"}, in_ready_a, 1'b1);
    check_eq({tag, "_valid_after"}, res_valid_a, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_exp = 1'b0;
    res_ready = 1'b0; in_data = 32'h0;
    clear_words();
    #2;
    check_eq("rst_in_ready", in_ready_a, 1'b1);
    check_eq("rst_res_valid", res_valid_a, 1'b0);
    check_eq("rst_res_bit", res_bit_a, 1'b0);
    check_eq("rst_res_match", res_match_a, 1'b0);
    check_eq("rst_test_cnt", test_cnt_a, 0);
    check_eq("rst_err_cnt", err_cnt_a, 0);
    check_eq("rst_frame_err", frame_err_a, 1'b0);
    check_eq("rst_vec_ones", $countones(vec_a), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // All-zero frame, expected 0.
    run_frame("f1_zero", 1'b0, 1'b0, 1'b1, 1, 0);

    // Word 2 sets vec[78], expected 0 -> mismatch.
    clear_words();
    words[2] = 32'h0000_4000;
    run_frame("f2_bit78", 1'b0, 1'b1, 1'b0, 2, 1);

    // Word 59 all ones: only vec[1893:1888] may change.
    clear_words();
    words[59] = 32'hFFFF_FFFF;
    send_words(60, 59, 1'b0);
    wait_result(lat_a, lat_b);
    check_eq("f3_lat1", lat_a, 2);
    check_eq("f3_lat3", lat_b, 4);
    check_eq("f3_vec_top", vec_a[1893:1888], 6'h3F);
    check_eq("f3_vec_ones", $countones(vec_a), 6);
    check_eq("f3_vec_top_b", vec_b[1893:1888], 6'h3F);
    check_eq("f3_res_match", res_match_a, 1'b1);
    check_eq("f3_test_cnt", test_cnt_a, 3);
    check_eq("f3_err_cnt", err_cnt_a, 1);
    ack();

    // Early in_last on word 10: framing error, no result.
    clear_words();
    words[2] = 32'h0000_4000;
    send_words(11, 10, 1'b0);
    check_eq("ferr_flag", frame_err_a, 1'b1);
    check_eq("ferr_flag_b", frame_err_b, 1'b1);
    for (int c = 0; c < 8; c++) begin
      check_eq("ferr_no_valid", {62'h0, res_valid_a, res_valid_b}, 64'h0);
      step();
    end
    check_eq("ferr_test_cnt", test_cnt_a, 3);
    check_eq("ferr_in_ready", in_ready_a, 1'b1);
    clear_words();
    run_frame("f4_after_ferr", 1'b1, 1'b0, 1'b0, 4, 2);
    check_eq("ferr_sticky", frame_err_a, 1'b1);

    // Result held with res_ready low while words are offered.
    clear_words();
    words[2] = 32'h0000_4000;
    send_words(60, 59, 1'b1);
    wait_result(lat_a, lat_b);
    check_eq("hold_lat1", lat_a, 2);
    check_eq("hold_lat3", lat_b, 4);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    in_last  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq("hold_valid", res_valid_a, 1'b1);
      check_eq("hold_valid_b", res_valid_b, 1'b1);
      check_eq("hold_res_bit", res_bit_a, 1'b1);
      check_eq("hold_res_match", res_match_a, 1'b1);
      check_eq("hold_in_ready", in_ready_a, 1'b0);
      check_eq("hold_vec_ones", $countones(vec_a), 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'h0;
    ack();
    check_eq("hold_in_ready_after", in_ready_a, 1'b1);
    check_eq("hold_valid_after", res_valid_a, 1'b0);
    check_eq("hold_test_cnt", test_cnt_a, 5);
    check_eq("hold_err_cnt", err_cnt_a, 2);

    // Reset asserted while word 30 is on the bus.
    clear_words();
    words[2] = 32'h0000_4000;
    send_words(30, -1, 1'b0);
    check_eq("mid_pre_vec78", vec_a[78], 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vec_ones", $countones(vec_a), 0);
    check_eq("mid_rst_test_cnt", test_cnt_a, 0);
    check_eq("mid_rst_err_cnt", err_cnt_a, 0);
    check_eq("mid_rst_frame_err", frame_err_a, 1'b0);
    check_eq("mid_rst_valid", res_valid_a, 1'b0);
    check_eq("mid_rst_in_ready", in_ready_a, 1'b1);
    in_valid = 1'b0;
    in_data  = 32'h0;
    step();
    rst_n = 1'b1;
    step();
    clear_words();
    run_frame("f6_post_rst", 1'b0, 1'b0, 1'b1, 1, 0);
    check_eq("post_rst_frame_err", frame_err_a, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cluster_vector_loader.md
# cluster_vector_loader

Sequential front end for the learned CPU-cluster output-bit circuits (`module_output_bit_*`). It assembles the 1894-bit state vector `i` from a 32-bit word stream and drives it onto the evaluator's input bus. It then samples the evaluator's single-bit result, compares it with the expected bit supplied with the frame, and returns a per-frame result plus running test and error counters. It is the producer/checker end of the `i[1893:0]` → `o` interface.

## Interface
- `VEC_W`, 1894, state vector width driven to the evaluator.
- `WORD_W`, 32, input stream word width.
- `EVAL_LAT`, 1, cycles (≥1) between the frame commit edge and the result sampling edge.
- `CNT_W`, 32, width of the test and error counters.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader accepts a word (high only in LOAD).
- `in_data`  in  WORD_W  stream word.
- `in_last`  in  1  marks the final word of a frame.
- `in_exp`  in  1  expected result bit, sampled with the `in_last` word.
- `vec`  out  VEC_W  state vector to the evaluator's `i`.
- `eval_o`  in  1  evaluator output `o`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `res_bit`  out  1  sampled `eval_o`.
- `res_match`  out  1  `res_bit == expected`.
- `test_cnt`  out  CNT_W  completed frames, saturating.
- `err_cnt`  out  CNT_W  mismatching frames, saturating.
- `frame_err`  out  1  sticky framing-error flag; cleared only by reset.

## Operation
- NUM_WORDS = ceil(VEC_W/WORD_W) = 60. LAST_BITS = VEC_W − 59·32 = 6.
- Word k is written to `vec[k*32 +: 32]`.
  - Word 59 writes only `vec[1893:1888]` from `in_data[5:0]`.
  - `in_data[31:6]` of word 59 is ignored.
- `vec` is written in place. It is stable in EVAL and RESP because no words are accepted then.
- FSM states:
  - LOAD: `in_ready=1`. Each transfer (`in_valid & in_ready`) writes one word and increments `word_idx`.
    - Transfer at `word_idx==59` with `in_last=1`: capture `in_exp`, load the wait counter with EVAL_LAT, go to EVAL, clear `word_idx`.
    - `in_last=1` at `word_idx<59`, or `in_last=0` at `word_idx==59`: set `frame_err`, clear `word_idx`, stay in LOAD. No result is produced; `vec` holds partial data.
  - EVAL: `in_ready=0`. The wait counter decrements each cycle. On the cycle it reaches 1:
    - register `res_bit=eval_o` and `res_match=(eval_o==exp)`;
    - increment `test_cnt`;
    - increment `err_cnt` if mismatch;
    - go to RESP.
  - RESP: `res_valid=1`, and `res_bit`/`res_match` are held. When `res_ready=1`, go to LOAD.
- Counters saturate at all-ones and never wrap.
- Reset values:
  - state LOAD, `word_idx` 0;
  - `vec` all-zero;
  - `res_valid`, `res_bit`, `res_match` 0;
  - `test_cnt`, `err_cnt` 0;
  - `frame_err` 0.
- `in_ready` is decoded from state, so it reads 1 while reset is held.
- Reset asserted mid-frame or mid-result aborts immediately. The next frame starts at word 0.

## Timing
- Last word accepted at edge T: EVAL during cycle T+1.
- `eval_o` is sampled at edge T+EVAL_LAT. `res_valid` is high from cycle T+EVAL_LAT+1.
- The evaluator must settle within EVAL_LAT cycles; the `module_output_bit_*` circuits are combinational, so EVAL_LAT=1 suffices.
- Result handshake at edge R: LOAD from cycle R+1, `in_ready=1`.
- Throughput with `in_valid` and `res_ready` tied high: one frame per 60+EVAL_LAT+1 cycles.
- `res_valid` and result fields are stable while `res_ready=0` (standard valid/ready; valid does not depend on ready).
- All outputs are registered except `in_ready`, which is a state decode.

## Structure
- Package `cluster_vec_pkg`: VEC_W, WORD_W, NUM_WORDS, LAST_BITS, CNT_W defaults, and the state enum {LOAD, EVAL, RESP}.
- Sub-module `sat_counter` (CNT_W-bit, enable-increment, saturating), instantiated twice for `test_cnt` and `err_cnt`.
- FSM, word index, wait counter and vector register live in the top module.

## Test plan
- Reset, then 60 zero words with `in_exp=0`, `eval_o` tied to `vec[78]` → `res_bit=0`, `res_match=1`, `test_cnt=1`, `err_cnt=0`.
- Word 2 = 0x0000_4000 (sets `vec[78]`), `in_exp=0` → `res_bit=1`, `res_match=0`, `err_cnt=1`, result visible 2 cycles after the last word.
- Word 59 = 0xFFFF_FFFF → `vec[1893:1888]=6'h3F`, no other bits changed. Same with EVAL_LAT=3 → `res_valid` 4 cycles after the last-word edge.
- `in_last` on word 10 → `frame_err=1`, no `res_valid`, `test_cnt` unchanged. The next full frame completes and `test_cnt` increments by 1.
- Hold `res_ready=0` for 20 cycles → `res_valid`, `res_bit` and `res_match` stable, `in_ready=0`, no words accepted. On release, `in_ready=1` next cycle.
- Assert `rst_n` low at word 30 → all outputs at reset values asynchronously. After release, a full frame loads from word 0 and `test_cnt=1`.
